// File: rtl/btn_capture_pkg.sv
// Shared types for the push-button capture front end: state encoding, button vector, one-hot test.
package btn_capture_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, WAIT_REL} btn_state_t;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // True when exactly one button is pressed.
  function automatic logic is_onehot(input btn_vec_t v);
    return (v != '0) && ((v & (v - btn_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer for the raw button levels; adds two cycles of latency, no backpressure.
module btn_sync2
  import btn_capture_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] d,
  output logic [NUM_BTN-1:0] q
);

  btn_vec_t meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/btn_onehot_capture.sv
// Debounces four buttons and emits each clean single press as a registered one-hot word; a press
// is valid DEBOUNCE_CYCLES edges after first sampled, held until ready_i. BTN_ONEHOT_SYNC2_EN adds an input synchronizer.
module btn_onehot_capture
  import btn_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               ready_i,
  output logic [NUM_BTN-1:0] onehot_o,
  output logic               valid_o,
  output logic               multi_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  btn_vec_t btn_s;

`ifdef BTN_ONEHOT_SYNC2_EN
  btn_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_i),
    .q     (btn_s)
  );
`else
  assign btn_s = btn_i;
`endif

  btn_state_t       state_q, state_nxt;
  btn_vec_t         cand_q, cand_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  btn_vec_t         onehot_nxt;
  logic             valid_nxt;
  logic             err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      onehot_o    <= '0;
      valid_o     <= 1'b0;
      multi_err_o <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cand_q      <= cand_nxt;
      cnt_q       <= cnt_nxt;
      onehot_o    <= onehot_nxt;
      valid_o     <= valid_nxt;
      multi_err_o <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cand_nxt   = cand_q;
    cnt_nxt    = cnt_q;
    onehot_nxt = onehot_o;
    valid_nxt  = valid_o;
    err_nxt    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (btn_s != '0) begin
          cand_nxt  = btn_s;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (btn_s == '0) begin
          state_nxt = IDLE;
        end else if (btn_s != cand_q) begin
          cand_nxt = btn_s;
          cnt_nxt  = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end else if (is_onehot(cand_q)) begin
          onehot_nxt = cand_q;
          valid_nxt  = 1'b1;
          state_nxt  = HOLD;
        end else begin
          // Chords are reported once and then must be fully released.
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_REL;
        end
      end

      HOLD: begin
        if (ready_i) begin
          onehot_nxt = '0;
          valid_nxt  = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (btn_s != '0) begin
          cnt_nxt = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_btn_onehot_capture.sv
// Directed bench for btn_onehot_capture with DEBOUNCE_CYCLES=4; expected values worked out by hand.
module tb_btn_onehot_capture;
  import btn_capture_pkg::*;

  localparam int DC = 4;
`ifdef BTN_ONEHOT_SYNC2_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_i = 4'b0000;
  logic       ready_i = 1'b0;
  logic [3:0] onehot_o;
  logic       valid_o;
  logic       multi_err_o;

  int checks = 0;
  int errors = 0;
  int seen;
  int bad;

  btn_onehot_capture #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_i       (btn_i),
    .ready_i     (ready_i),
    .onehot_o    (onehot_o),
    .valid_o     (valid_o),
    .multi_err_o (multi_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2;
    check("rst_valid", int'(valid_o), 0);
    check("rst_onehot", int'(onehot_o), 0);
    check("rst_err", int'(multi_err_o), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_state", int'(dut.state_q), int'(IDLE));

    // Single press, ready already high, then held through acceptance.
    btn_i = 4'b0100; ready_i = 1'b1;
    tick(DC + SL);
    check("press_early_valid", int'(valid_o), 0);
    tick(1);
    check("press_valid", int'(valid_o), 1);
    check("press_onehot", int'(onehot_o), 4'b0100);
    tick(1);
    check("press_valid_drop", int'(valid_o), 0);
    check("press_onehot_clr", int'(onehot_o), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (valid_o) seen++;
    end
    check("held_no_repeat", seen, 0);
    btn_i = 4'b0000;
    tick(DC + SL);
    check("release_idle", int'(dut.state_q), int'(IDLE));
    btn_i = 4'b0100;
    tick(DC + SL + 1);
    check("repress_valid", int'(valid_o), 1);
    btn_i = 4'b0000;
    tick(1 + DC + SL);
    check("repress_idle", int'(dut.state_q), int'(IDLE));

    // Bouncing button never reaches the debounce threshold.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      btn_i = 4'b0010;
      tick(2);
      if (valid_o) seen++;
      btn_i = 4'b0000;
      tick(2);
      if (valid_o) seen++;
    end
    tick(2 + SL);
    check("bounce_no_valid", seen, 0);
    check("bounce_idle", int'(dut.state_q), int'(IDLE));

    // Chord is rejected with a single error pulse.
    btn_i = 4'b0101;
    tick(DC + SL);
    check("multi_early_err", int'(multi_err_o), 0);
    tick(1);
    check("multi_err", int'(multi_err_o), 1);
    check("multi_valid", int'(valid_o), 0);
    btn_i = 4'b0000;
    tick(1);
    check("multi_err_pulse", int'(multi_err_o), 0);
    tick(DC - 1 + SL);
    check("multi_idle", int'(dut.state_q), int'(IDLE));
    btn_i = 4'b1000;
    tick(DC + SL + 1);
    check("after_multi_valid", int'(valid_o), 1);
    check("after_multi_onehot", int'(onehot_o), 4'b1000);
    btn_i = 4'b0000;
    tick(1 + DC + SL);

    // Backpressure: word held while ready is low and buttons change.
    ready_i = 1'b0;
    btn_i = 4'b0001;
    tick(DC + SL + 1);
    check("bp_valid", int'(valid_o), 1);
    btn_i = 4'b1000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!valid_o || onehot_o != 4'b0001) bad++;
    end
    check("bp_hold", bad, 0);
    ready_i = 1'b1;
    tick(1);
    check("bp_xfer_drop", int'(valid_o), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (valid_o) seen++;
    end
    check("bp_single_xfer", seen, 0);
    btn_i = 4'b0000;
    tick(DC + SL);

    // Reset while holding a press.
    ready_i = 1'b0;
    btn_i = 4'b0010;
    tick(DC + SL + 1);
    check("hold_valid", int'(valid_o), 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(valid_o), 0);
    check("arst_onehot", int'(onehot_o), 0);
    btn_i = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(2 + SL);
    check("arst_idle", int'(dut.state_q), int'(IDLE));
    check("arst_valid_after", int'(valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
